// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator and pixel pipeline.
// Produces x/y fetch requests and a linear pixel address, then delays the
// blanking and sync flags by FETCH_LAT enabled cycles so that they line up
// with the colour returned by the framebuffer.
// Optional feature: define VGA_TIMING_TESTPAT_EN to add a test_mode input
// that replaces the fetched colour with eight vertical colour bars.
module vga_timing_gen #(
    parameter int H_VISIBLE = 800,
    parameter int H_FPORCH  = 56,
    parameter int H_SYNC    = 120,
    parameter int H_BPORCH  = 64,
    parameter int V_VISIBLE = 600,
    parameter int V_FPORCH  = 37,
    parameter int V_SYNC    = 6,
    parameter int V_BPORCH  = 23,
    parameter int COLOR_W   = 1,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int FETCH_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
`ifdef VGA_TIMING_TESTPAT_EN
    input  logic                   test_mode,
`endif
    input  logic [3*COLOR_W-1:0]   color_in,
    output logic                   req,
    output logic [11:0]            req_x,
    output logic [11:0]            req_y,
    output logic [19:0]            pixel,
    output logic                   line,
    output logic                   frame,
    output logic                   vga_hsync,
    output logic                   vga_vsync,
    output logic [COLOR_W-1:0]     vga_red,
    output logic [COLOR_W-1:0]     vga_green,
    output logic [COLOR_W-1:0]     vga_blue
);

    // ------------------------------------------------------------------
    // Derived timing constants. Region bounds are 13 bit so that a region
    // ending exactly at 4096 still compares correctly against a 12-bit count.
    // ------------------------------------------------------------------
    localparam int H_TOTAL = H_VISIBLE + H_FPORCH + H_SYNC + H_BPORCH;
    localparam int V_TOTAL = V_VISIBLE + V_FPORCH + V_SYNC + V_BPORCH;

    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
    localparam logic [12:0] H_VIS_END  = 13'(H_VISIBLE);
    localparam logic [12:0] H_SYNC_BEG = 13'(H_VISIBLE + H_FPORCH);
    localparam logic [12:0] H_SYNC_END = 13'(H_VISIBLE + H_FPORCH + H_SYNC);
    localparam logic [12:0] V_VIS_END  = 13'(V_VISIBLE);
    localparam logic [12:0] V_SYNC_BEG = 13'(V_VISIBLE + V_FPORCH);
    localparam logic [12:0] V_SYNC_END = 13'(V_VISIBLE + V_FPORCH + V_SYNC);

    localparam logic HS_ACT = 1'(HSYNC_POL);
    localparam logic VS_ACT = 1'(VSYNC_POL);

    // Tap word carried through the fetch-latency pipeline:
    // {x (test pattern only), visible, hsync active, vsync active}.
`ifdef VGA_TIMING_TESTPAT_EN
    localparam int TAP_W = 15;
`else
    localparam int TAP_W = 3;
`endif

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic        at_line_end;
    logic        at_frame_end;
    logic        vis_now;
    logic        hs_now;
    logic        vs_now;

    assign at_line_end  = (h_cnt_q == H_LAST);
    assign at_frame_end = at_line_end && (v_cnt_q == V_LAST);
    assign vis_now      = ({1'b0, h_cnt_q} < H_VIS_END) && ({1'b0, v_cnt_q} < V_VIS_END);
    assign hs_now       = ({1'b0, h_cnt_q} >= H_SYNC_BEG) && ({1'b0, h_cnt_q} < H_SYNC_END);
    assign vs_now       = ({1'b0, v_cnt_q} >= V_SYNC_BEG) && ({1'b0, v_cnt_q} < V_SYNC_END);

    // Next raster position: h wraps at end of line, v steps once per h wrap.
    always_comb begin
        h_cnt_d = h_cnt_q + 12'd1;
        v_cnt_d = v_cnt_q;
        if (at_line_end) begin
            h_cnt_d = 12'd0;
            v_cnt_d = (v_cnt_q == V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
        end
    end

    // Counter state, advanced only on enabled cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q <= 12'd0;
            v_cnt_q <= 12'd0;
        end else if (en) begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Linear pixel address. pix_cnt_q is the address the next visible
    // position will carry; pixel_q is the address of the registered request
    // and holds through blanking until the end-of-frame clears it.
    // ------------------------------------------------------------------
    logic [19:0] pix_cnt_q, pix_cnt_d;
    logic [19:0] pixel_q, pixel_d;

    // Address bookkeeping for the position currently on the counters.
    always_comb begin
        pix_cnt_d = pix_cnt_q;
        pixel_d   = pixel_q;
        if (at_frame_end) begin
            pix_cnt_d = 20'd0;
            pixel_d   = 20'd0;
        end else if (vis_now) begin
            pix_cnt_d = pix_cnt_q + 20'd1;
            pixel_d   = pix_cnt_q;
        end
    end

    // ------------------------------------------------------------------
    // Stage 0: request, position, raw syncs and line/frame strobes.
    // ------------------------------------------------------------------
    logic        req_q;
    logic [11:0] req_x_q;
    logic [11:0] req_y_q;
    logic        hs_raw_q;
    logic        vs_raw_q;
    logic        line_q;
    logic        frame_q;

    // Register the counter position; strobes are forced low on idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q     <= 1'b0;
            req_x_q   <= 12'd0;
            req_y_q   <= 12'd0;
            hs_raw_q  <= 1'b0;
            vs_raw_q  <= 1'b0;
            line_q    <= 1'b0;
            frame_q   <= 1'b0;
            pix_cnt_q <= 20'd0;
            pixel_q   <= 20'd0;
        end else begin
            line_q  <= en && at_line_end;
            frame_q <= en && at_frame_end;
            if (en) begin
                req_q     <= vis_now;
                req_x_q   <= h_cnt_q;
                req_y_q   <= v_cnt_q;
                hs_raw_q  <= hs_now;
                vs_raw_q  <= vs_now;
                pix_cnt_q <= pix_cnt_d;
                pixel_q   <= pixel_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Fetch-latency pipeline for visibility, syncs (and x for the bars).
    // ------------------------------------------------------------------
    logic [TAP_W-1:0] tap_in;
    logic [TAP_W-1:0] tap_out;

`ifdef VGA_TIMING_TESTPAT_EN
    assign tap_in = {req_x_q, req_q, hs_raw_q, vs_raw_q};
`else
    assign tap_in = {req_q, hs_raw_q, vs_raw_q};
`endif

    generate
        if (FETCH_LAT == 0) begin : g_no_lat
            assign tap_out = tap_in;
        end else begin : g_lat
            logic [TAP_W-1:0] pipe_q [FETCH_LAT];

            // Shift register of FETCH_LAT taps; reset discards in-flight pixels.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < FETCH_LAT; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else if (en) begin
                    pipe_q[0] <= tap_in;
                    for (int i = 1; i < FETCH_LAT; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            assign tap_out = pipe_q[FETCH_LAT-1];
        end
    endgenerate

    logic tap_vis;
    logic tap_hs;
    logic tap_vs;

    assign tap_vis = tap_out[2];
    assign tap_hs  = tap_out[1];
    assign tap_vs  = tap_out[0];

    // ------------------------------------------------------------------
    // Colour source selection. Bar index bit 2/1/0 drives R/G/B, which
    // matches the channel order of color_in (B in the low slice).
    // ------------------------------------------------------------------
    logic       use_bar;
    logic [2:0] bar_idx;

`ifdef VGA_TIMING_TESTPAT_EN
    logic [11:0] tap_x;
    assign tap_x   = tap_out[14:3];
    assign use_bar = test_mode;
    assign bar_idx = 3'(({3'b000, tap_x} * 15'd8) / 15'(H_VISIBLE));
`else
    assign use_bar = 1'b0;
    assign bar_idx = 3'b000;
`endif

    logic [3*COLOR_W-1:0] rgb_d;
    logic [3*COLOR_W-1:0] rgb_q;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic [COLOR_W-1:0] chan_in;
            logic [COLOR_W-1:0] chan_src;
            assign chan_in  = color_in[gi*COLOR_W +: COLOR_W];
            assign chan_src = use_bar ? {COLOR_W{bar_idx[gi]}} : chan_in;
            assign rgb_d[gi*COLOR_W +: COLOR_W] = tap_vis ? chan_src : '0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output stage: colour and polarity-adjusted syncs, loaded when the
    // fetched colour is valid.
    // ------------------------------------------------------------------
    logic hsync_q;
    logic vsync_q;

    // Pin registers; colour is sampled only on enabled cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q   <= '0;
            hsync_q <= ~HS_ACT;
            vsync_q <= ~VS_ACT;
        end else if (en) begin
            rgb_q   <= rgb_d;
            hsync_q <= tap_hs ? HS_ACT : ~HS_ACT;
            vsync_q <= tap_vs ? VS_ACT : ~VS_ACT;
        end
    end

    assign req       = req_q;
    assign req_x     = req_x_q;
    assign req_y     = req_y_q;
    assign pixel     = pixel_q;
    assign line      = line_q;
    assign frame     = frame_q;
    assign vga_hsync = hsync_q;
    assign vga_vsync = vsync_q;
    assign vga_red   = rgb_q[2*COLOR_W +: COLOR_W];
    assign vga_green = rgb_q[1*COLOR_W +: COLOR_W];
    assign vga_blue  = rgb_q[0 +: COLOR_W];

endmodule
